trap_controller: RTL and testbench
==================================

// Module: trap_controller
// PURPOSE
//  Sequences machine-mode trap entry and MRET through the single-port CSR file. On a trap it
//  writes mepc, then mcause, then reads mtvec. On MRET it reads mepc. In both cases it then
//  issues a one-cycle PC redirect to fetch. When idle, it passes the pipeline's CSR accesses
//  straight through to the CSR file. It sits between the execute/trap-detect logic and the CSR file.
// PARAMETERS
//  XLEN  32  data/address width
// PORTS
//  clk               in   1     clock
//  reset             in   1     reset, asynchronous, active-high
//  trap_valid        in   1     exception request (ecall/ebreak/misaligned/illegal); sampled in IDLE only
//  trap_cause        in   4     exception code, written to mcause
//  trap_pc           in   XLEN  PC of the faulting instruction
//  mret_valid        in   1     MRET request; sampled in IDLE only
//  pipe_csr_raddr    in   12    pipeline CSR read address
//  pipe_csr_we       in   1     pipeline CSR write enable
//  pipe_csr_waddr    in   12    pipeline CSR write address
//  pipe_csr_wdata    in   XLEN  pipeline CSR write data
//  csr_rdata         in   XLEN  CSR file registered read data
//  csr_ready         in   1     CSR file ready (low for 1 cycle on a new valid read access)
//  csr_raddr         out  12    CSR file read address
//  csr_we            out  1     CSR file write enable
//  csr_waddr         out  12    CSR file write address
//  csr_wdata         out  XLEN  CSR file write data
//  trapped           out  1     high while writing trap CSRs (drives CSR file trapped input)
//  busy              out  1     high whenever state != IDLE; the pipeline stalls on it
//  redirect_valid    out  1     one-cycle pulse: fetch must jump to redirect_pc
//  redirect_pc       out  XLEN  redirect target, bits [1:0] always 0
// BEHAVIOUR
//  States: IDLE, WR_MEPC, WR_MCAUSE, RD_MTVEC, RD_MEPC, REDIRECT.
//  Reset (async): state=IDLE. The following registered outputs clear to 0: redirect_valid,
//    redirect_pc, and the internal target and read-wait flag.
//  IDLE:
//    - The CSR port mirrors the pipe_* inputs. trapped=0, busy=0.
//    - trap_valid=1 -> WR_MEPC. Also latch trap_pc & ~3 and trap_cause.
//    - Else mret_valid=1 -> RD_MEPC.
//    - If both are asserted, the trap wins and mret is dropped.
//    - In the acceptance cycle csr_we is forced to 0, so the trapping/MRET instruction never writes.
//  WR_MEPC (1 cycle): csr_we=1, waddr=12'h341, wdata=latched pc, trapped=1 -> WR_MCAUSE.
//  WR_MCAUSE (1 cycle): csr_we=1, waddr=12'h342, wdata={XLEN-4 zeros, cause}, trapped=1.
//    Bit XLEN-1 is 0 (exceptions only, no interrupts). Next state: RD_MTVEC.
//  RD_MTVEC / RD_MEPC:
//    - Drive csr_raddr = 12'h305 (mtvec) or 12'h341 (mepc). csr_we=0.
//    - The first cycle in the state sets a wait flag; csr_rdata is not sampled in that cycle.
//    - Data is captured on the first later cycle with csr_ready=1. Minimum dwell is 2 cycles;
//      the state is held indefinitely while csr_ready=0.
//    - Captured target = csr_rdata & ~3 (mtvec mode bits ignored: exceptions always go to BASE).
//    - On capture -> REDIRECT.
//  REDIRECT (1 cycle): redirect_valid=1, redirect_pc=target -> IDLE.
//    - redirect_valid is 0 in all other states. redirect_pc holds its last value.
//  Outside IDLE the CSR port is owned by the controller and pipe_* inputs are ignored.
//    When not writing, csr_raddr = 0 and csr_we = 0.
//  New trap_valid/mret_valid while busy=1 is ignored; the pipeline must hold the request.
//  Latency:
//    - Trap acceptance to redirect pulse: 5 cycles minimum (WR_MEPC, WR_MCAUSE, 2x RD, REDIRECT).
//    - MRET acceptance to redirect pulse: 3 cycles minimum.
//  Reset mid-sequence: return to IDLE immediately. Partially written CSRs are not rolled back.
// TESTING
//  Bench CSR model: registered read, csr_ready low for 1 cycle on each new valid read address.
//    mtvec resets to 0x1000.
//  1. trap_valid, cause=11, pc=0x100 -> mepc write 0x100, then mcause write 0x0000000B
//     (trapped=1 both cycles), redirect_pc=0x1000 pulse at cycle 5, busy high for 5 cycles.
//  2. mepc=0x104, then mret_valid -> redirect_pc=0x104 at cycle 3; no CSR write issued.
//  3. trap_valid and mret_valid together, pc=0x200, cause=2 -> full trap sequence,
//     redirect 0x1000; MRET ignored.
//  4. trap pc=0x103, then mtvec=0x2001 -> mepc written 0x100, redirect_pc=0x2000.
//  5. In IDLE, pipe write of mtvec=0x3000 passes through the same cycle. During busy, pipe_csr_we=1
//     is not forwarded (csr_we only in WR states).
//  6. Reset asserted during WR_MCAUSE -> state IDLE, busy=0, redirect_valid=0 at once;
//     a subsequent ecall completes normally.

Source files
------------

// File: rtl/trap_controller_if.sv
// CSR file port shared by the trap controller (master) and the single-port CSR file (slave).
// The read data is registered inside the CSR file; ready drops for one cycle on a new read.
interface trap_controller_if #(
    parameter int XLEN = 32
);
    logic [11:0]     raddr;
    logic            we;
    logic [11:0]     waddr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            ready;

    modport master (
        output raddr, we, waddr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  raddr, we, waddr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap entry / MRET sequencer: writes mepc and mcause, reads mtvec or mepc
// through the single CSR port, then pulses a PC redirect. Idle traffic passes straight through.
module trap_controller #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trap_valid,
    input  logic [3:0]        trap_cause,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              mret_valid,
    input  logic [11:0]       pipe_csr_raddr,
    input  logic              pipe_csr_we,
    input  logic [11:0]       pipe_csr_waddr,
    input  logic [XLEN-1:0]   pipe_csr_wdata,
    trap_controller_if.master csr,
    output logic              trapped,
    output logic              busy,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc
);

    localparam logic [11:0] ADDR_MTVEC  = 12'h305;
    localparam logic [11:0] ADDR_MEPC   = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE = 12'h342;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [2:0] {
        IDLE,
        WR_MEPC,
        WR_MCAUSE,
        RD_MTVEC,
        RD_MEPC,
        REDIRECT
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [3:0]      cause_q;
    logic            rd_wait;

    // NOTE: the latched pc/cause are reset along with the control state so a single
    // async-reset always_ff covers every register; their reset value is never observed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            pc_q           <= '0;
            cause_q        <= '0;
            rd_wait        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (trap_valid) begin
                        pc_q    <= trap_pc & ALIGN_MASK;
                        cause_q <= trap_cause;
                        state   <= WR_MEPC;
                    end else if (mret_valid) begin
                        state <= RD_MEPC;
                    end
                end
                WR_MEPC:   state <= WR_MCAUSE;
                WR_MCAUSE: state <= RD_MTVEC;
                RD_MTVEC, RD_MEPC: begin
                    // The first cycle in a read state only presents the address.
                    if (!rd_wait) begin
                        rd_wait <= 1'b1;
                    end else if (csr.ready) begin
                        rd_wait        <= 1'b0;
                        redirect_pc    <= csr.rdata & ALIGN_MASK;
                        redirect_valid <= 1'b1;
                        state          <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    redirect_valid <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every port signal gets a default before the case so no path infers a latch.
    always_comb begin
        csr.raddr = '0;
        csr.we    = 1'b0;
        csr.waddr = '0;
        csr.wdata = '0;
        case (state)
            IDLE: begin
                csr.raddr = pipe_csr_raddr;
                csr.we    = pipe_csr_we & ~trap_valid & ~mret_valid;
                csr.waddr = pipe_csr_waddr;
                csr.wdata = pipe_csr_wdata;
            end
            WR_MEPC: begin
                csr.we    = 1'b1;
                csr.waddr = ADDR_MEPC;
                csr.wdata = pc_q;
            end
            WR_MCAUSE: begin
                csr.we    = 1'b1;
                csr.waddr = ADDR_MCAUSE;
                csr.wdata = {{(XLEN-4){1'b0}}, cause_q};
            end
            RD_MTVEC: csr.raddr = ADDR_MTVEC;
            RD_MEPC:  csr.raddr = ADDR_MEPC;
            default: ;
        endcase
    end

    assign trapped = (state == WR_MEPC) || (state == WR_MCAUSE);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: idle pass-through table, directed trap/MRET/reset sequences and
// randomized requests scored against an architectural model of mepc/mcause/mtvec.
module tb_trap_controller;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            trap_valid, mret_valid, pipe_csr_we;
    logic [3:0]      trap_cause;
    logic [XLEN-1:0] trap_pc, pipe_csr_wdata;
    logic [11:0]     pipe_csr_raddr, pipe_csr_waddr;
    logic            trapped, busy, redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    always #5 clk = ~clk;

    trap_controller_if #(.XLEN(XLEN)) csr ();

    trap_controller #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_valid(mret_valid),
        .pipe_csr_raddr(pipe_csr_raddr), .pipe_csr_we(pipe_csr_we),
        .pipe_csr_waddr(pipe_csr_waddr), .pipe_csr_wdata(pipe_csr_wdata),
        .csr(csr),
        .trapped(trapped), .busy(busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // CSR file model: registered read, ready low for 1+extra_stall cycles on a new read address.
    logic [XLEN-1:0] mem [0:4095];
    logic [11:0]     last_raddr;
    int              stall_cnt, extra_stall;
    logic            new_access;

    assign new_access = (csr.raddr != last_raddr) && (csr.raddr != 12'h000);
    assign csr.ready  = !new_access && (stall_cnt == 0);

    always @(posedge clk) begin
        if (csr.we) mem[csr.waddr] <= csr.wdata;
        csr.rdata  <= mem[csr.raddr];
        last_raddr <= csr.raddr;
        if (new_access)         stall_cnt <= extra_stall;
        else if (stall_cnt > 0) stall_cnt <= stall_cnt - 1;
    end

    // Monitor of controller-issued writes and of the trapped flag.
    typedef struct packed { logic [11:0] addr; logic [XLEN-1:0] data; } wr_t;
    wr_t wr_log[$];
    int  trapped_bad;

    always @(negedge clk) begin
        if (!reset) begin
            if (busy && csr.we) wr_log.push_back({csr.waddr, csr.wdata});
            if (trapped !== (busy && csr.we)) trapped_bad++;
        end
    end

    int vectors, miscompares;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural reference state.
    logic [XLEN-1:0] ref_mepc, ref_mtvec;

    task automatic pipe_write(input logic [11:0] addr, input logic [XLEN-1:0] data);
        @(negedge clk);
        pipe_csr_raddr = 12'h000;
        pipe_csr_we    = 1'b1;
        pipe_csr_waddr = addr;
        pipe_csr_wdata = data;
        #1;
        check("pass_we", csr.we, 1'b1);
        check("pass_waddr", csr.waddr, addr);
        check("pass_wdata", csr.wdata, data);
        if (addr == 12'h305) ref_mtvec = data;
        if (addr == 12'h341) ref_mepc  = data;
        @(negedge clk);
        pipe_csr_we = 1'b0;
    endtask

    task automatic do_request(input bit tv, input bit mv, input logic [3:0] cause,
                              input logic [XLEN-1:0] pc, input int stall);
        logic [XLEN-1:0] exp_target;
        wr_t exp_wr[$];
        int  exp_lat, n, busy_cnt;
        bit  seen;
        if (tv) begin
            ref_mepc   = pc & ~32'h3;
            exp_wr.push_back({12'h341, ref_mepc});
            exp_wr.push_back({12'h342, {28'h0, cause}});
            exp_target = ref_mtvec & ~32'h3;
            exp_lat    = 5 + stall;
        end else begin
            exp_target = ref_mepc & ~32'h3;
            exp_lat    = 3 + stall;
        end
        extra_stall = stall;
        @(negedge clk);
        trap_valid = tv; mret_valid = mv; trap_cause = cause; trap_pc = pc;
        pipe_csr_raddr = 12'h000;
        pipe_csr_we    = 1'b1;           // must never reach the CSR file during the sequence
        pipe_csr_waddr = 12'h305;
        pipe_csr_wdata = 32'hdead_beef;
        wr_log.delete();
        trapped_bad = 0;
        #1 check("accept_we", csr.we, 1'b0);
        n = 0; seen = 0; busy_cnt = 0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            trap_valid = 1'b0; mret_valid = 1'b0;
            if (busy) busy_cnt++;
            if (redirect_valid) begin
                seen = 1;
                pipe_csr_we = 1'b0;
            end
        end
        pipe_csr_we = 1'b0;
        check("redirect_seen", seen, 1'b1);
        check("latency", n, exp_lat);
        check("busy_cycles", busy_cnt, exp_lat);
        check("redirect_pc", redirect_pc, exp_target);
        check("write_count", wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
            check("write_addr", wr_log[i].addr, exp_wr[i].addr);
            check("write_data", wr_log[i].data, exp_wr[i].data);
        end
        check("trapped_flag", trapped_bad, 0);
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("pulse_end", redirect_valid, 1'b0);
    endtask

    typedef struct {
        logic        tv, mv, we;
        logic [11:0] raddr, waddr;
        logic [31:0] wdata;
        logic        exp_we;
        logic [11:0] exp_raddr, exp_waddr;
        logic [31:0] exp_wdata;
    } idle_vec_t;

    idle_vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 12'h305, 12'h305, 32'h0000_aaaa, 1'b1, 12'h305, 12'h305, 32'h0000_aaaa};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 12'h341, 12'h300, 32'h0000_1234, 1'b0, 12'h341, 12'h300, 32'h0000_1234};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 12'h342, 12'h341, 32'h0000_0005, 1'b0, 12'h342, 12'h341, 32'h0000_0005};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 12'h007, 12'h008, 32'h0000_0009, 1'b0, 12'h007, 12'h008, 32'h0000_0009};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 12'h300, 12'h305, 32'hffff_0000, 1'b0, 12'h300, 12'h305, 32'hffff_0000};

        vectors = 0; miscompares = 0; trapped_bad = 0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'h305] = 32'h0000_1000;
        ref_mtvec = 32'h0000_1000;
        ref_mepc  = '0;
        last_raddr = '0; stall_cnt = 0; extra_stall = 0;
        reset = 1'b1;
        trap_valid = 1'b0; mret_valid = 1'b0; trap_cause = '0; trap_pc = '0;
        pipe_csr_raddr = '0; pipe_csr_we = 1'b0; pipe_csr_waddr = '0; pipe_csr_wdata = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_redirect_valid", redirect_valid, 1'b0);
        check("rst_redirect_pc", redirect_pc, '0);
        check("rst_trapped", trapped, 1'b0);
        reset = 1'b0;

        // Idle pass-through; requests are withdrawn before the next edge.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            trap_valid = vecs[i].tv; mret_valid = vecs[i].mv; pipe_csr_we = vecs[i].we;
            pipe_csr_raddr = vecs[i].raddr; pipe_csr_waddr = vecs[i].waddr;
            pipe_csr_wdata = vecs[i].wdata;
            #1;
            check("tbl_we", csr.we, vecs[i].exp_we);
            check("tbl_raddr", csr.raddr, vecs[i].exp_raddr);
            check("tbl_waddr", csr.waddr, vecs[i].exp_waddr);
            check("tbl_wdata", csr.wdata, vecs[i].exp_wdata);
            check("tbl_busy", busy, 1'b0);
            #1;
            trap_valid = 1'b0; mret_valid = 1'b0; pipe_csr_we = 1'b0; pipe_csr_raddr = '0;
        end

        do_request(1'b1, 1'b0, 4'd11, 32'h0000_0100, 0);     // ecall, default mtvec
        do_request(1'b1, 1'b1, 4'd2,  32'h0000_0200, 0);     // trap beats mret
        pipe_write(12'h341, 32'h0000_0104);
        do_request(1'b0, 1'b1, 4'd0,  32'h0, 0);             // mret to 0x104
        pipe_write(12'h305, 32'h0000_3000);
        do_request(1'b1, 1'b0, 4'd3,  32'h0000_0400, 1);     // read held by ready low
        pipe_write(12'h305, 32'h0000_2001);
        do_request(1'b1, 1'b0, 4'd4,  32'h0000_0103, 0);     // misaligned pc, mtvec mode bits

        // Reset during WR_MCAUSE: mepc already written, sequence abandoned.
        @(negedge clk);
        trap_valid = 1'b1; trap_cause = 4'd3; trap_pc = 32'h0000_0300;
        @(negedge clk);
        trap_valid = 1'b0;
        @(negedge clk);
        check("mid_trapped", trapped, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_redirect", redirect_valid, 1'b0);
        check("mid_rst_trapped", trapped, 1'b0);
        ref_mepc = 32'h0000_0300;
        @(negedge clk);
        reset = 1'b0;
        do_request(1'b0, 1'b1, 4'd0,  32'h0, 0);             // mepc from the partial trap
        do_request(1'b1, 1'b0, 4'd11, 32'h0000_0500, 0);

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 4))
                0: pipe_write(12'h305, $urandom);
                1: pipe_write(12'h341, $urandom);
                2: do_request(1'b1, 1'b0, 4'($urandom), $urandom, $urandom_range(0, 2));
                3: do_request(1'b0, 1'b1, 4'd0, 32'h0, $urandom_range(0, 2));
                default: do_request(1'b1, 1'b1, 4'($urandom), $urandom, $urandom_range(0, 2));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
